neuron_mac: RTL

NEURON_MAC -- requirements
Module: neuron_mac

---
 rtl/neuron_mac.sv | 131 +++++++++++++
 1 files changed

// File: rtl/neuron_mac.sv
// Fixed-point multiply-accumulate neuron: bias plus K weighted inputs,
// floor-scaled back to N bits with saturation and optional ReLU.
module neuron_mac #(
  parameter int N    = 8,
  parameter int FRAC = 6,
  parameter int K    = 4,
  parameter int ACT  = 0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [N-1:0] b,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] w,
  input  logic [N-1:0] x,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] out,
  output logic         ovr,
  output logic         busy
);

  localparam int CW = (K > 1) ? $clog2(K) : 1;
  localparam int AW = 2 * N + $clog2(K) + 1;
  localparam logic [CW-1:0] LAST = CW'(K - 1);
  localparam logic signed [AW-1:0] MAXV = {{(AW - N + 1){1'b0}}, {(N - 1){1'b1}}};
  localparam logic signed [AW-1:0] MINV = {{(AW - N + 1){1'b1}}, {(N - 1){1'b0}}};

  typedef enum logic [1:0] {IDLE, ACC, OUT} stateT;

  stateT                 r_state;
  stateT                 w_nextState;
  logic signed [AW-1:0]  r_acc;
  logic [CW-1:0]         r_count;
  logic [N-1:0]          r_out;
  logic                  r_ovr;

  logic signed [2*N-1:0] w_prod;
  logic signed [AW-1:0]  w_prodExt;
  logic signed [AW-1:0]  w_biasExt;
  logic signed [AW-1:0]  w_accNext;
  logic signed [AW-1:0]  w_shift;
  logic [N-1:0]          w_resOut;
  logic                  w_resOvr;
  logic                  w_beat;
  logic                  w_lastBeat;

  assign w_beat     = (r_state == ACC) && in_valid;
  assign w_lastBeat = w_beat && (r_count == LAST);
  assign w_prod     = $signed(w) * $signed(x);
  assign w_prodExt  = {{(AW - 2 * N){w_prod[2*N-1]}}, w_prod};
  assign w_biasExt  = {{(AW - N){b[N-1]}}, b};
  assign w_accNext  = r_acc + w_prodExt;
  // Arithmetic shift gives floor rounding toward minus infinity.
  assign w_shift    = w_accNext >>> FRAC;

  always_comb begin
    w_resOvr = 1'b0;
    w_resOut = w_shift[N-1:0];
    if (w_shift > MAXV) begin
      w_resOut = MAXV[N-1:0];
      w_resOvr = 1'b1;
    end else if (w_shift < MINV) begin
      w_resOut = MINV[N-1:0];
      w_resOvr = 1'b1;
    end
    if (ACT == 1 && w_resOut[N-1]) begin
      w_resOut = '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE:    if (start) w_nextState = ACC;
      ACC:     if (w_lastBeat) w_nextState = OUT;
      OUT:     if (out_ready) w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (r_state == ACC);
    out_valid = (r_state == OUT);
    busy      = (r_state != IDLE);
  end

  // The result is registered on the edge that takes the last beat, so it
  // appears together with out_valid.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_acc   <= '0;
      r_count <= '0;
      r_out   <= '0;
      r_ovr   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_acc   <= w_biasExt <<< FRAC;
            r_count <= '0;
          end
        end
        ACC: begin
          if (w_beat) begin
            r_acc   <= w_accNext;
            r_count <= w_lastBeat ? '0 : r_count + CW'(1);
          end
          if (w_lastBeat) begin
            r_out <= w_resOut;
            r_ovr <= w_resOvr;
          end
        end
        default: ;
      endcase
    end
  end

  assign out = r_out;
  assign ovr = r_ovr;

endmodule
